// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and Avalon-side memory signals around the arbiter.
// The slave modport is the arbiter's view: it serves both requesters and
// drives the memory bus. The master modport is the environment's view.
interface mem_arbiter_if;
  // fetch requester
  logic        f_read;
  logic [31:0] f_address;
  logic [31:0] f_readdata;
  logic        f_done;
  // data requester
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_readdata;
  logic        d_done;
  // Avalon memory side
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata;
  logic        waitrequest;

  modport slave (
    input  f_read, f_address,
    input  d_read, d_write, d_address, d_writedata, d_byteenable,
    input  mem_readdata, waitrequest,
    output f_readdata, f_done,
    output d_readdata, d_done,
    output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable
  );

  modport master (
    output f_read, f_address,
    output d_read, d_write, d_address, d_writedata, d_byteenable,
    output mem_readdata, waitrequest,
    input  f_readdata, f_done,
    input  d_readdata, d_done,
    input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter onto one Avalon master port.
// Latency: request in IDLE cycle N -> bus cycle N+1 -> done N+2 -> IDLE N+3.
// Backpressure: waitrequest freezes the bus state and all mem_* outputs.
module mem_arbiter (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic          busy,
  output logic          timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUS_F = 2'd1;
  localparam logic [1:0] BUS_D = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  // 1 when the data port owned the most recently completed transaction;
  // in RESP it therefore also names whose done pulse to raise.
  logic        last_data;
  logic [7:0]  stall_cnt;
  logic        timeout_q;
  logic [31:0] f_rdata_q;
  logic [31:0] d_rdata_q;

  logic        f_req;
  logic        d_req;
  logic        in_bus;
  logic        bus_done;
  logic        d_is_load;

  assign f_req     = bus.f_read;
  assign d_req     = bus.d_read | bus.d_write;
  assign in_bus    = (state == BUS_F) || (state == BUS_D);
  assign bus_done  = in_bus && !bus.waitrequest;
  // a simultaneous read+write request is carried out as a write
  assign d_is_load = bus.d_read && !bus.d_write;

  // next-state: arbitrate only from IDLE, leave a bus state when memory accepts
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (f_req && (!d_req || last_data)) begin
          state_nxt = BUS_F;
        end else if (d_req) begin
          state_nxt = BUS_D;
        end
      end
      BUS_F, BUS_D: begin
        if (!bus.waitrequest) begin
          state_nxt = RESP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // last-grant record, updated when a bus transaction completes
  always_ff @(posedge clk) begin
    if (reset) begin
      last_data <= 1'b1;
    end else if (bus_done) begin
      last_data <= (state == BUS_D);
    end
  end

  // stall counter: cleared when a bus state is entered, saturating count of wait cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 8'd0;
    end else if (state == IDLE && state_nxt != IDLE) begin
      stall_cnt <= 8'd0;
    end else if (in_bus && bus.waitrequest && stall_cnt != 8'hFF) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  // sticky timeout, raised on the same edge the stall counter reaches 255
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (in_bus && bus.waitrequest && stall_cnt == 8'hFE) begin
      timeout_q <= 1'b1;
    end
  end

  // read data capture at completion; stores leave the load register alone
  always_ff @(posedge clk) begin
    if (reset) begin
      f_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else if (bus_done) begin
      if (state == BUS_F) begin
        f_rdata_q <= bus.mem_readdata;
      end else if (d_is_load) begin
        d_rdata_q <= bus.mem_readdata;
      end
    end
  end

  // memory-side outputs follow the granted requester's operands while on the bus
  always_comb begin
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = 32'd0;
    bus.mem_writedata  = 32'd0;
    bus.mem_byteenable = 4'd0;
    case (state)
      BUS_F: begin
        bus.mem_read       = 1'b1;
        bus.mem_address    = bus.f_address;
        bus.mem_byteenable = 4'b1111;
      end
      BUS_D: begin
        bus.mem_read       = d_is_load;
        bus.mem_write      = bus.d_write;
        bus.mem_address    = bus.d_address;
        bus.mem_writedata  = bus.d_writedata;
        bus.mem_byteenable = bus.d_byteenable;
      end
      default: begin
      end
    endcase
  end

  assign bus.f_done     = (state == RESP) && !last_data;
  assign bus.d_done     = (state == RESP) &&  last_data;
  assign bus.f_readdata = f_rdata_q;
  assign bus.d_readdata = d_rdata_q;
  assign busy           = (state != IDLE);
  assign timeout        = timeout_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset. Ports: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high).
REQ-002 Fetch port SHALL be:
- f_read input 1: fetch read request.
- f_address input 32: fetch byte address.
- f_readdata output 32: captured fetch data.
- f_done output 1: one-cycle fetch completion.
REQ-003 Data port SHALL be:
- d_read input 1: data read request.
- d_write input 1: data write request.
- d_address input 32: data byte address.
- d_writedata input 32: store data.
- d_byteenable input 4: store/load lanes.
- d_readdata output 32: captured load data.
- d_done output 1: one-cycle data completion.
REQ-004 Avalon master port SHALL be:
- mem_address output 32.
- mem_read output 1.
- mem_write output 1.
- mem_writedata output 32.
- mem_byteenable output 4.
- mem_readdata input 32.
- waitrequest input 1.
REQ-005 Status outputs SHALL be:
- busy output 1: a bus transaction is in progress.
- timeout output 1: sticky stall error.

Function
REQ-006 The FSM SHALL have four states: IDLE, BUS_F, BUS_D and RESP.
REQ-007 In IDLE, if exactly one requester is active, the FSM SHALL go to that requester's BUS state at the next edge. The fetch requester is active when f_read=1; the data requester is active when d_read|d_write=1.
REQ-008 If both requesters are active in IDLE, the grant SHALL be round-robin: the requester not granted last wins. The last-grant register SHALL reset to "data", so fetch wins the first tie.
REQ-009 In BUS_F the outputs SHALL be:
- mem_read=1, mem_write=0.
- mem_address=f_address.
- mem_byteenable=4'b1111.
- mem_writedata=0.
REQ-010 In BUS_D the outputs SHALL be:
- mem_read=d_read&~d_write and mem_write=d_write. If d_read and d_write are both high, the access is treated as a write.
- mem_address=d_address, mem_byteenable=d_byteenable, mem_writedata=d_writedata.
REQ-011 Outside the BUS states, mem_read, mem_write, mem_address, mem_writedata and mem_byteenable SHALL all be 0.
REQ-012 While waitrequest=1 in a BUS state, the FSM SHALL hold the state and all mem_* outputs unchanged.
REQ-013 A transaction SHALL complete at the edge where the FSM is in a BUS state and waitrequest=0. At that edge:
- mem_readdata is captured (reads only) into f_readdata or d_readdata.
- The FSM goes to RESP.
- The granted requester is recorded as last grant.
REQ-014 In RESP, exactly one of f_done or d_done (the granted requester's) SHALL be 1, for one cycle only. The FSM SHALL then return to IDLE.
REQ-015 Readdata registers SHALL hold their value until the next read completion to the same port. A data write SHALL leave d_readdata unchanged.
REQ-016 Latency with waitrequest=0: request seen in IDLE at cycle N, mem_read/mem_write high in N+1, done high in N+2, IDLE again in N+3. Each waitrequest-high cycle adds one cycle.
REQ-017 Requesters SHALL hold their request and operands stable until done is seen, and SHALL drop the request the cycle after. Requests seen in RESP SHALL be ignored. The arbiter re-arbitrates only in IDLE.
REQ-018 busy SHALL be 1 in BUS_F, BUS_D and RESP, and 0 in IDLE.
REQ-019 An 8-bit stall counter SHALL clear on entry to any BUS state and increment on each cycle in a BUS state with waitrequest=1. The counter saturates at 255.
REQ-020 When the stall counter reaches 255, timeout SHALL be set to 1 and stay 1 until reset. The transaction is not aborted.

Reset
REQ-021 When reset=1 at a rising edge, the block SHALL do all of the following on that edge, even mid-transaction:
- FSM goes to IDLE.
- All outputs go to 0, including f_readdata, d_readdata, timeout and busy.
- Stall counter clears to 0.
- Last grant is set to "data".
- No done pulse is issued for the aborted transaction.

Verification
REQ-022 Fetch read: f_read=1, f_address=20, waitrequest=0, mem_readdata=50 -> mem_read=1 with mem_address=20 and mem_byteenable=1111 one cycle later; f_done=1 and f_readdata=50 the cycle after that.
REQ-023 Stalled data write: d_write=1, d_address=16, d_writedata=32'hF9876543, d_byteenable=0011, waitrequest=1 for 3 cycles -> mem_write=1 with all mem_* outputs stable for 4 cycles; d_done pulses once; d_readdata unchanged.
REQ-024 Round-robin: f_read and d_read both held continuously, each re-asserted one cycle after its done -> grants alternate fetch, data, fetch, data; never two consecutive grants to the same port.
REQ-025 Reset mid-operation: reset=1 during BUS_D with waitrequest=1 -> next cycle mem_read=mem_write=0, busy=0, no d_done; a subsequent tie grants fetch.
REQ-026 Timeout: waitrequest held at 1 for 260 cycles during BUS_F -> timeout=1 from stall count 255 onward; waitrequest then 0 with mem_readdata=7 -> f_done=1, f_readdata=7, timeout stays 1 until reset.
REQ-027 Read+write conflict: d_read=d_write=1 -> mem_write=1 and mem_read=0.
